page_normalizer: RTL

Byte-packing, page-splitting stage that sits directly upstream of the compression arbiter. It accepts an arbitrary host AXI stream whose beats may be short, and compacts the bytes into full 64-byte beats. It cuts the stream into pages of at most PAGE_SIZE bytes, so every downstream compression core sees a normalized page: whole beats with a tlast-marked, possibly partial final beat.

---
 rtl/page_normalizer_pkg.sv | 24 ++
 rtl/page_normalizer_byte_packer.sv | 65 ++++++
 rtl/page_normalizer.sv | 86 ++++++++
 3 files changed

// File: rtl/page_normalizer_pkg.sv
// Shared constants and types for the page normalizer.
package page_normalizer_pkg;

  localparam int unsigned AXI_DATA_BITS   = 512;
  localparam int unsigned AXI_ID_BITS     = 6;
  localparam int unsigned PAGE_SIZE       = 4096;
  localparam int unsigned PAGE_SIZE_WIDTH = 13;
  localparam int unsigned BEAT_BYTES      = AXI_DATA_BITS / 8;

  typedef logic [PAGE_SIZE_WIDTH-1:0] page_size_t;

  // Holding-buffer byte count, 0..2*BEAT_BYTES; 128 needs the eighth bit.
  typedef logic [7:0] fill_t;

  // Byte count of a single beat, 0..BEAT_BYTES.
  typedef logic [6:0] beat_cnt_t;

  // Low-aligned keep for n bytes, saturating at a full beat.
  function automatic logic [BEAT_BYTES-1:0] keep_mask(input fill_t n);
    if (n >= fill_t'(BEAT_BYTES)) return '1;
    return ({{(BEAT_BYTES-1){1'b0}}, 1'b1} << n[5:0]) - {{(BEAT_BYTES-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/page_normalizer_byte_packer.sv
// Two-beat holding buffer: shifts out emitted bytes, then appends accepted bytes at the fill.
module byte_packer
  import page_normalizer_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_fire_i,
  input  logic [AXI_DATA_BITS-1:0] in_data_i,
  input  beat_cnt_t                in_bytes_i,
  input  logic                     out_fire_i,
  output logic [AXI_DATA_BITS-1:0] out_data_o,
  output logic [BEAT_BYTES-1:0]    out_keep_o,
  output beat_cnt_t                out_bytes_o,
  output fill_t                    fill_o
);

  localparam int unsigned BufBits = 2 * AXI_DATA_BITS;

  logic [BufBits-1:0]       data_q, data_d;
  logic [BufBits-1:0]       shifted, in_word;
  logic [AXI_DATA_BITS-1:0] in_masked;
  logic [BEAT_BYTES-1:0]    in_keep;
  fill_t                    fill_q, fill_d, fill_s;

  // Output view: low beat of the buffer, byte count and keep derived from the fill.
  always_comb begin
    out_bytes_o = (fill_q >= fill_t'(BEAT_BYTES)) ? beat_cnt_t'(BEAT_BYTES) : fill_q[6:0];
    out_keep_o  = keep_mask(fill_q);
    out_data_o  = data_q[AXI_DATA_BITS-1:0];
    fill_o      = fill_q;
  end

  // Next state: shift first, then append; bytes above the fill are kept at zero.
  always_comb begin
    shifted = data_q;
    fill_s  = fill_q;
    if (out_fire_i) begin
      shifted = data_q >> {out_bytes_o, 3'b000};
      fill_s  = fill_q - fill_t'(out_bytes_o);
    end
    in_keep = keep_mask(fill_t'(in_bytes_i));
    for (int i = 0; i < int'(BEAT_BYTES); i++) begin
      in_masked[i*8 +: 8] = in_keep[i] ? in_data_i[i*8 +: 8] : 8'h00;
    end
    in_word = {{AXI_DATA_BITS{1'b0}}, in_masked};
    data_d  = shifted;
    fill_d  = fill_s;
    if (in_fire_i) begin
      data_d = shifted | (in_word << {fill_s, 3'b000});
      fill_d = fill_s + fill_t'(in_bytes_i);
    end
  end

  // Buffer and fill registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      fill_q <= '0;
    end else begin
      data_q <= data_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/page_normalizer.sv
// Compacts a short-beat AXI stream into full beats and cuts it into pages of PAGE_BYTES.
module page_normalizer
  import page_normalizer_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = PAGE_SIZE
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [AXI_DATA_BITS-1:0] i_data_tdata,
  input  logic [BEAT_BYTES-1:0]    i_data_tkeep,
  input  logic                     i_data_tlast,
  input  logic                     i_data_tvalid,
  output logic                     i_data_tready,
  output logic [AXI_DATA_BITS-1:0] o_data_tdata,
  output logic [BEAT_BYTES-1:0]    o_data_tkeep,
  output logic                     o_data_tlast,
  output logic                     o_data_tvalid,
  output logic [AXI_ID_BITS-1:0]   o_data_tid,
  input  logic                     o_data_tready
);

  page_size_t page_cnt_q, page_cnt_d;
  logic       flush_q, flush_d;
  logic       live_q;
  fill_t      fill, fill_after_out;
  beat_cnt_t  out_bytes, in_bytes;
  logic       out_valid, out_last, out_fire, in_ready, in_fire, page_end, pkt_end;

  byte_packer u_packer (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_fire_i   (in_fire),
    .in_data_i   (i_data_tdata),
    .in_bytes_i  (in_bytes),
    .out_fire_i  (out_fire),
    .out_data_o  (o_data_tdata),
    .out_keep_o  (o_data_tkeep),
    .out_bytes_o (out_bytes),
    .fill_o      (fill)
  );

  // Handshake glue; input ready looks through the output handshake.
  always_comb begin
    out_valid      = (fill >= fill_t'(BEAT_BYTES)) || (flush_q && (fill != '0));
    page_end       = (page_cnt_q + page_size_t'(out_bytes)) == page_size_t'(PAGE_BYTES);
    pkt_end        = flush_q && (fill <= fill_t'(BEAT_BYTES));
    out_last       = out_valid && (page_end || pkt_end);
    out_fire       = out_valid && o_data_tready;
    fill_after_out = out_fire ? (fill - fill_t'(out_bytes)) : fill;
    in_ready       = live_q && !flush_q && (fill_after_out <= fill_t'(BEAT_BYTES));
    in_fire        = i_data_tvalid && in_ready;
    in_bytes       = beat_cnt_t'($countones(i_data_tkeep));
    i_data_tready  = in_ready;
    o_data_tvalid  = out_valid;
    o_data_tlast   = out_last;
    o_data_tid     = '0;
  end

  // Page counter and flush flag; an empty zero-length packet never raises flush.
  always_comb begin
    page_cnt_d = page_cnt_q;
    flush_d    = flush_q;
    if (out_fire) begin
      page_cnt_d = out_last ? '0 : (page_cnt_q + page_size_t'(out_bytes));
    end
    if (in_fire && i_data_tlast) begin
      flush_d = (fill_after_out + fill_t'(in_bytes)) != '0;
    end else if (out_fire && pkt_end) begin
      flush_d = 1'b0;
    end
  end

  // State registers; live_q keeps input ready low until the first clock after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      page_cnt_q <= '0;
      flush_q    <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      page_cnt_q <= page_cnt_d;
      flush_q    <= flush_d;
      live_q     <= 1'b1;
    end
  end

endmodule
